// File: rtl/ising_sweep_controller.sv
// Sweep sequencer for the recurrent Ising sampler: issues one masked
// matrix-vector multiply per iteration, adds noise to the returned local
// fields and updates all spins in parallel by sign.
module ising_sweep_controller #(
  parameter int unsigned N          = 2,
  parameter int unsigned DATABITS   = 32,
  parameter int unsigned MM_LATENCY = 2,
  parameter int unsigned ITERBITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ITERBITS-1:0]   num_iters,
  input  logic                  stop_on_stable,
  input  logic [N-1:0]          init_spins,
  input  logic [DATABITS*N-1:0] noise,
  input  logic [DATABITS*N-1:0] mm_result,
  output logic [DATABITS-1:0]   mm_ready,
  output logic [N-1:0]          mm_mask,
  output logic                  noise_ack,
  output logic [N-1:0]          spins,
  output logic [ITERBITS-1:0]   iter_count,
  output logic                  busy,
  output logic                  done,
  output logic                  stable
);

  localparam int unsigned CNTW = (MM_LATENCY > 1) ? $clog2(MM_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNTW-1:0]      r_wait_cnt;
  logic [ITERBITS-1:0]  r_num_iters;
  logic                 r_stop_on_stable;
  logic [N-1:0]         r_spins;
  logic [ITERBITS-1:0]  r_iter_count;
  logic                 r_stable;
  logic                 r_mm_ready;
  logic                 r_noise_ack;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_load;
  logic                 w_update;
  logic [N-1:0]         w_new_spins;
  logic                 w_no_change;
  logic [ITERBITS-1:0]  w_iter_inc;
  logic signed [DATABITS:0] w_sum [N];

  // Sign decision per spin on a widened sum so extreme fields cannot wrap.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_sum[i] = $signed({mm_result[i*DATABITS + DATABITS - 1], mm_result[i*DATABITS +: DATABITS]})
               + $signed({noise[i*DATABITS + DATABITS - 1], noise[i*DATABITS +: DATABITS]});
      w_new_spins[i] = !w_sum[i][DATABITS] && (w_sum[i] != '0);
    end
  end

  assign w_no_change = (w_new_spins == r_spins);
  assign w_iter_inc  = r_iter_count + ITERBITS'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic and datapath strobes; abort overrides every transition.
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_update = 1'b0;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_load = 1'b1;
            w_next = (num_iters == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: w_next = S_WAIT;
        S_WAIT: begin
          if (r_wait_cnt == CNTW'(MM_LATENCY - 1)) w_next = S_UPDATE;
        end
        S_UPDATE: begin
          w_update = 1'b1;
          if ((w_iter_inc == r_num_iters) || (r_stop_on_stable && w_no_change)) w_next = S_DONE;
          else                                                                w_next = S_ISSUE;
        end
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Multiplier latency counter: cleared outside WAIT, counts WAIT cycles.
  always_ff @(posedge clk) begin
    if (!rst_n)                                         r_wait_cnt <= '0;
    else if ((r_state == S_WAIT) && (w_next == S_WAIT)) r_wait_cnt <= r_wait_cnt + CNTW'(1);
    else                                                r_wait_cnt <= '0;
  end

  // Run configuration, spin vector, iteration count and stability flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_num_iters      <= '0;
      r_stop_on_stable <= 1'b0;
      r_spins          <= '0;
      r_iter_count     <= '0;
      r_stable         <= 1'b0;
    end else if (w_load) begin
      r_num_iters      <= num_iters;
      r_stop_on_stable <= stop_on_stable;
      r_spins          <= init_spins;
      r_iter_count     <= '0;
      r_stable         <= 1'b0;
    end else if (w_update) begin
      r_spins          <= w_new_spins;
      r_iter_count     <= w_iter_inc;
      r_stable         <= w_no_change;
    end
  end

  // Status and handshake outputs, registered from the upcoming state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mm_ready  <= 1'b0;
      r_noise_ack <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_mm_ready  <= (w_next == S_ISSUE);
      r_noise_ack <= (w_next == S_UPDATE);
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_DONE);
    end
  end

  assign mm_ready   = DATABITS'(r_mm_ready);
  assign mm_mask    = r_spins;
  assign noise_ack  = r_noise_ack;
  assign spins      = r_spins;
  assign iter_count = r_iter_count;
  assign busy       = r_busy;
  assign done       = r_done;
  assign stable     = r_stable;

endmodule

// File: tb/tb_ising_sweep_controller.sv
// Directed bench for ising_sweep_controller with a 2x2 coupling model.
module tb_ising_sweep_controller;

  localparam int unsigned N    = 2;
  localparam int unsigned DB   = 32;
  localparam int unsigned LAT  = 2;
  localparam int unsigned IB   = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [IB-1:0]   num_iters;
  logic            stop_on_stable;
  logic [N-1:0]    init_spins;
  logic [DB*N-1:0] noise;
  logic [DB*N-1:0] mm_result;
  logic [DB-1:0]   mm_ready;
  logic [N-1:0]    mm_mask;
  logic            noise_ack;
  logic [N-1:0]    spins;
  logic [IB-1:0]   iter_count;
  logic            busy;
  logic            done;
  logic            stable;

  int checks = 0;
  int errors = 0;

  // Coupling matrix, per-row bias and per-spin noise of the bench model.
  int     j00, j01, j10, j11;
  longint b0, b1, n0, n1;
  longint f0, f1;

  always #5 clk = ~clk;

  ising_sweep_controller #(.N(N), .DATABITS(DB), .MM_LATENCY(LAT), .ITERBITS(IB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_iters(num_iters),
    .stop_on_stable(stop_on_stable), .init_spins(init_spins), .noise(noise),
    .mm_result(mm_result), .mm_ready(mm_ready), .mm_mask(mm_mask), .noise_ack(noise_ack),
    .spins(spins), .iter_count(iter_count), .busy(busy), .done(done), .stable(stable)
  );

  // Multiplier model: field_i = sum_j J[i][j]*mask[j] + bias_i.
  always_comb begin
    f0 = (mm_mask[0] ? longint'(j00) : 64'sd0) + (mm_mask[1] ? longint'(j01) : 64'sd0) + b0;
    f1 = (mm_mask[0] ? longint'(j10) : 64'sd0) + (mm_mask[1] ? longint'(j11) : 64'sd0) + b1;
  end
  assign mm_result = {f1[31:0], f0[31:0]};
  assign noise     = {n1[31:0], n0[31:0]};

  typedef struct {
    logic [1:0] init;
    int         iters;
    bit         stop;
    int         j00, j01, j10, j11;
    longint     b0, b1, n0, n1;
    logic [1:0] exp_spins;
    int         exp_iters;
    bit         exp_stable;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Apply one vector, wait (bounded) for done, then check results and pulse counts.
  task automatic run_vec(input int idx, input vec_t v);
    int lat, rdy_cnt, ack_cnt, done_cnt;
    logic [DB-1:0] rdy_max;
    bit seen;
    lat = 0; rdy_cnt = 0; ack_cnt = 0; done_cnt = 0; rdy_max = '0; seen = 0;
    j00 = v.j00; j01 = v.j01; j10 = v.j10; j11 = v.j11;
    b0 = v.b0; b1 = v.b1; n0 = v.n0; n1 = v.n1;
    init_spins = v.init; num_iters = IB'(v.iters); stop_on_stable = v.stop;
    start = 1'b1;
    for (int c = 0; c < 1000 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (mm_ready != '0) begin rdy_cnt++; if (mm_ready > rdy_max) rdy_max = mm_ready; end
      if (noise_ack) ack_cnt++;
      if (done) begin done_cnt++; seen = 1; end
    end
    check($sformatf("v%0d done_seen", idx), 64'(seen), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mm_ready != '0) rdy_cnt++;
      if (noise_ack) ack_cnt++;
      if (done) done_cnt++;
    end
    check($sformatf("v%0d spins", idx),      64'(spins),      64'(v.exp_spins));
    check($sformatf("v%0d mm_mask", idx),    64'(mm_mask),    64'(v.exp_spins));
    check($sformatf("v%0d iter_count", idx), 64'(iter_count), 64'(v.exp_iters));
    check($sformatf("v%0d stable", idx),     64'(stable),     64'(v.exp_stable));
    check($sformatf("v%0d ready_pulses", idx), 64'(rdy_cnt),  64'(v.exp_iters));
    check($sformatf("v%0d ready_value", idx),  64'(rdy_max),  (v.exp_iters > 0) ? 64'd1 : 64'd0);
    check($sformatf("v%0d ack_pulses", idx),   64'(ack_cnt),  64'(v.exp_iters));
    check($sformatf("v%0d done_pulses", idx),  64'(done_cnt), 64'd1);
    check($sformatf("v%0d done_latency", idx), 64'(lat),      64'(v.exp_iters * (LAT + 2) + 1));
    check($sformatf("v%0d busy_after", idx),   64'(busy),     64'd0);
  endtask

  initial begin
    int dcount;
    // init, iters, stop, J00 J01 J10 J11, b0 b1 n0 n1, exp spins, exp iters, exp stable
    vecs[0] = '{2'b01, 1,   1'b0, 0, 5, 5, 0, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 2'b10, 1, 1'b0};
    vecs[1] = '{2'b01, 4,   1'b0, 0, 5, 5, 0, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 2'b01, 4, 1'b0};
    vecs[2] = '{2'b11, 100, 1'b1, 5, 5, 5, 5, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 2'b11, 1, 1'b1};
    vecs[3] = '{2'b00, 1,   1'b0, 0, 0, 0, 0, -64'sd3, 64'sh7FFFFFFF, 64'sd3, 64'sd1, 2'b10, 1, 1'b0};
    vecs[4] = '{2'b11, 1,   1'b0, 0, 0, 0, 0, -64'sd2147483648, 64'sh7FFFFFFF, -64'sd1, 64'sh7FFFFFFF, 2'b10, 1, 1'b0};
    vecs[5] = '{2'b10, 0,   1'b0, 0, 5, 5, 0, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 2'b10, 0, 1'b0};
    vecs[6] = '{2'b01, 1,   1'b0, 0, 5, 5, 0, 64'sd0, 64'sd0, 64'sd0, -64'sd5, 2'b00, 1, 1'b0};
    vecs[7] = '{2'b11, 3,   1'b0, 5, 5, 5, 5, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 2'b11, 3, 1'b1};
    vecs[8] = '{2'b01, 4,   1'b1, 0, 5, 5, 0, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 2'b01, 4, 1'b0};

    // Reset with every input active: outputs must stay at zero.
    j00 = 5; j01 = 5; j10 = 5; j11 = 5; b0 = 64'sd7; b1 = 64'sd7; n0 = 64'sd1; n1 = 64'sd1;
    rst_n = 1'b0; start = 1'b1; abort = 1'b1; num_iters = 16'd5;
    stop_on_stable = 1'b1; init_spins = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst mm_ready", 64'(mm_ready), 64'd0);
      check("rst outputs", 64'({spins, iter_count, noise_ack, busy, done, stable}), 64'd0);
    end
    start = 1'b0; abort = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("post_rst busy", 64'(busy), 64'd0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Abort while waiting on the multiplier.
    j00 = 0; j01 = 5; j10 = 5; j11 = 0; b0 = 0; b1 = 0; n0 = 0; n1 = 0;
    init_spins = 2'b01; num_iters = 16'd4; stop_on_stable = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("abort pre ready", 64'(mm_ready), 64'd1);
    @(negedge clk);
    check("abort in_wait busy", 64'(busy), 64'd1);
    check("abort in_wait ready", 64'(mm_ready), 64'd0);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort ready", 64'(mm_ready), 64'd0);
    dcount = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || busy || (mm_ready != '0)) dcount++;
    end
    check("abort no_activity", 64'(dcount), 64'd0);
    check("abort spins_kept", 64'(spins), 64'd1);
    check("abort iter_kept", 64'(iter_count), 64'd0);

    // Start and config changes while busy are ignored.
    init_spins = 2'b01; num_iters = 16'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    init_spins = 2'b11; num_iters = 16'd7; stop_on_stable = 1'b1; start = 1'b1;
    @(negedge clk);
    @(negedge clk); start = 1'b0;
    dcount = 0;
    for (int c = 0; c < 40 && dcount == 0; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("busy_start done_seen", 64'(dcount), 64'd1);
    check("busy_start spins", 64'(spins), 64'd1);
    check("busy_start iters", 64'(iter_count), 64'd2);
    dcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy) dcount++;
    end
    check("busy_start no_restart", 64'(dcount), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
